sar_search: RTL

SAR_SEARCH -- requirements
Module: sar_search

---
 rtl/sar_pkg.sv | 21 ++
 rtl/sar_search.sv | 114 +++++++++++
 2 files changed

// File: rtl/sar_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sar_pkg
// Description : Shared definitions for the successive-approximation search
//               block: state encoding and default search width.
// Revision    : 1.0 - initial release
// ============================================================================
package sar_pkg;

  // Default search width in bits (legal range 2..8).
  localparam int SAR_W_DEFAULT = 4;

  // Controller state encoding.
  typedef logic [1:0] sar_state_t;

  localparam sar_state_t ST_IDLE  = 2'd0;
  localparam sar_state_t ST_PROBE = 2'd1;
  localparam sar_state_t ST_DONE  = 2'd2;

endpackage : sar_pkg
`default_nettype wire

// File: rtl/sar_search.sv
`default_nettype none
// ============================================================================
// Module      : sar_search
// Description : Successive-approximation search controller. Drives a trial
//               value to an external combinational comparator, samples its
//               g/e/l answer every cycle and resolves one bit per step, MSB
//               first, with early exit on equality.
// Ports       : clk     - clock, all state on rising edge
//               rst_n   - asynchronous active-low reset
//               start   - request a search (honoured only when idle)
//               g/e/l   - comparator: target >, ==, < probe
//               probe   - registered trial value to the comparator
//               result  - registered search result, held until next start
//               busy    - high while probing
//               done    - one-cycle completion pulse
//               err     - comparator answer was not one-hot (sticky per search)
//               steps   - comparisons consumed by the last search
// Revision    : 1.0 - initial release
// ============================================================================
import sar_pkg::*;

module sar_search #(
  parameter int W = SAR_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     g,
  input  logic                     e,
  input  logic                     l,
  output logic [W-1:0]             probe,
  output logic [W-1:0]             result,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [$clog2(W+1)-1:0]   steps
);

  localparam int IDX_W = $clog2(W);

  localparam logic [W-1:0] c_one = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] c_msb = c_one << (W - 1);

  sar_state_t        r_state;
  logic [IDX_W-1:0]  r_idx;      // bit position currently being decided

  logic              w_onehot;
  logic [W-1:0]      w_next_bit; // trial bit for the next lower position

  assign w_onehot   = ({g, e, l} == 3'b100) || ({g, e, l} == 3'b010) ||
                      ({g, e, l} == 3'b001);
  assign w_next_bit = c_one << (r_idx - 1'b1);

  assign busy = (r_state == ST_PROBE);
  assign done = (r_state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      probe   <= '0;
      result  <= '0;
      err     <= 1'b0;
      steps   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_PROBE;
            r_idx   <= IDX_W'(W - 1);
            probe   <= c_msb;
            result  <= '0;
            err     <= 1'b0;
            steps   <= '0;
          end
        end

        ST_PROBE: begin
          steps <= steps + 1'b1;
          if (!w_onehot) begin
            // Inconsistent comparator: abandon the search, keep result.
            err     <= 1'b1;
            r_state <= ST_DONE;
          end else if (e) begin
            result  <= probe;
            r_state <= ST_DONE;
          end else begin
            // A "greater" answer keeps the trial bit; "less" drops it, which
            // is the same as rebuilding the next trial from the kept prefix.
            if (g) begin
              result <= probe;
            end
            if (r_idx != '0) begin
              probe <= (g ? probe : result) | w_next_bit;
              r_idx <= r_idx - 1'b1;
            end else begin
              r_state <= ST_DONE;
            end
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : sar_search
`default_nettype wire
